// File: rtl/unpacker_multi.sv
// unpacker_multi
//   Splits a packed word of packed_width_p bits into packed_width_p/elem_width_p
//   elements and emits them one per cycle through a registered output stage.
//   The next word is accepted in the same cycle as the previous word's final
//   element move, so back-to-back words stream without a bubble.
//
// Parameters
//   packed_width_p : input word width (integer multiple of elem_width_p)
//   elem_width_p   : output element width (at least two elements per word)
//   msb_first_p    : 0 emits the LSB slice first, 1 emits the MSB slice first
//
// Ports
//   clk_i      : clock, rising edge
//   reset_ni   : asynchronous active-low reset
//   packed_i   : packed input word
//   valid_i    : input valid
//   ready_o    : input ready (combinational, low while reset_ni is low)
//   count_i    : valid elements in the word minus one   (UNPACKER_MULTI_LAST_EN)
//   last_i     : word ends a frame                       (UNPACKER_MULTI_LAST_EN)
//   unpacked_o : output element
//   valid_o    : output valid
//   ready_i    : output ready
//   last_o     : final element of a frame                (UNPACKER_MULTI_LAST_EN)
//
// Optional feature macro: UNPACKER_MULTI_LAST_EN enables partial words
// (count_i) and end-of-frame marking (last_i / last_o). Without it every word
// emits exactly packed_width_p/elem_width_p elements.
module unpacker_multi #(
  parameter int packed_width_p = 8,
  parameter int elem_width_p   = 2,
  parameter bit msb_first_p    = 1'b0,
  localparam int elems_lp = packed_width_p / elem_width_p,
  localparam int cnt_w_lp = (elems_lp > 1) ? $clog2(elems_lp) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [packed_width_p-1:0] packed_i,
  input  logic                      valid_i,
  output logic                      ready_o,
`ifdef UNPACKER_MULTI_LAST_EN
  input  logic [cnt_w_lp-1:0]       count_i,
  input  logic                      last_i,
  output logic                      last_o,
`endif
  output logic [elem_width_p-1:0]   unpacked_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  typedef enum logic {
    IDLE   = 1'b0,
    UNPACK = 1'b1
  } state_e;

  localparam logic [cnt_w_lp-1:0] max_cnt_lp = cnt_w_lp'(elems_lp - 1);

  state_e                    state_reg, state_next;
  logic [packed_width_p-1:0] buf_reg;
  logic [cnt_w_lp-1:0]       idx_reg;
  logic [cnt_w_lp-1:0]       count_l;
  logic [elem_width_p-1:0]   data_reg;
  logic                      valid_reg;
  logic [elem_width_p-1:0]   slice_l [elems_lp];

  logic elem_move;
  logic final_elem;
  logic final_move;
  logic ready_l;
  logic in_fire;

  // Element k of the buffered word; the order flip is resolved at
  // elaboration so the runtime mux only ever indexes by idx_reg.
  genvar gi;
  generate
    for (gi = 0; gi < elems_lp; gi++) begin : g_slice
      if (msb_first_p) begin : g_msb
        assign slice_l[gi] = buf_reg[(elems_lp-1-gi)*elem_width_p +: elem_width_p];
      end else begin : g_lsb
        assign slice_l[gi] = buf_reg[gi*elem_width_p +: elem_width_p];
      end
    end
  endgenerate

  // An element can move whenever the output register is empty or is being
  // drained this cycle.
  assign elem_move  = (state_reg == UNPACK) && (!valid_reg || ready_i);
  assign final_elem = (idx_reg == count_l);
  assign final_move = elem_move && final_elem;
  // Accepting during the final move is what keeps word-to-word throughput
  // gapless; reset_ni gates ready so nothing is accepted while held in reset.
  assign ready_l    = reset_ni && ((state_reg == IDLE) || final_move);
  assign in_fire    = valid_i && ready_l;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_fire) state_next = UNPACK;
      UNPACK:  if (final_move && !in_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg <= IDLE;
      buf_reg   <= '0;
      idx_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // A reload on the final move uses the old buffer for this cycle's
      // element and replaces it at the same edge.
      if (in_fire) begin
        buf_reg <= packed_i;
        idx_reg <= '0;
      end else if (elem_move) begin
        idx_reg <= idx_reg + 1'b1;
      end
      if (elem_move) begin
        data_reg  <= slice_l[idx_reg];
        valid_reg <= 1'b1;
      end else if (valid_reg && ready_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

`ifdef UNPACKER_MULTI_LAST_EN
  logic [cnt_w_lp-1:0] count_reg;
  logic [cnt_w_lp-1:0] count_clamped;
  logic                last_word_reg;
  logic                last_reg;

  // Counts beyond the last element are only representable when the element
  // count is not a power of two; otherwise the clamp is a pass-through.
  generate
    if ((2 ** cnt_w_lp) == elems_lp) begin : g_cnt_pass
      assign count_clamped = count_i;
    end else begin : g_cnt_clamp
      assign count_clamped = (count_i > max_cnt_lp) ? max_cnt_lp : count_i;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_reg     <= '0;
      last_word_reg <= 1'b0;
      last_reg      <= 1'b0;
    end else begin
      if (in_fire) begin
        count_reg     <= count_clamped;
        last_word_reg <= last_i;
      end
      if (elem_move) begin
        last_reg <= last_word_reg && final_elem;
      end else if (valid_reg && ready_i) begin
        last_reg <= 1'b0;
      end
    end
  end

  assign count_l = count_reg;
  assign last_o  = last_reg;
`else
  assign count_l = max_cnt_lp;
`endif

  assign ready_o    = ready_l;
  assign unpacked_o = data_reg;
  assign valid_o    = valid_reg;

endmodule

// File: tb/tb_unpacker_multi.sv
module tb_unpacker_multi;

  localparam int ELEMS = 4;
`ifdef UNPACKER_MULTI_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_ni;
  // 8/2 instances (LSB-first and MSB-first share the same stimulus)
  logic [7:0]  a_packed;
  logic        a_valid, a_ready_i;
  logic [1:0]  a_count;
  logic        a_last;
  logic        a_ready_o, a_valid_o, a_last_o;
  logic [1:0]  a_unp;
  logic        m_ready_o, m_valid_o, m_last_o;
  logic [1:0]  m_unp;
  // 32/8 instance
  logic [31:0] w_packed;
  logic        w_valid, w_ready_i;
  logic [1:0]  w_count;
  logic        w_last;
  logic        w_ready_o, w_valid_o, w_last_o;
  logic [7:0]  w_unp;

`ifndef UNPACKER_MULTI_LAST_EN
  assign a_last_o = 1'b0;
  assign m_last_o = 1'b0;
  assign w_last_o = 1'b0;
`endif

  unpacker_multi #(.packed_width_p(8), .elem_width_p(2), .msb_first_p(1'b0)) u_lsb (
    .clk_i(clk), .reset_ni(reset_ni), .packed_i(a_packed), .valid_i(a_valid), .ready_o(a_ready_o),
`ifdef UNPACKER_MULTI_LAST_EN
    .count_i(a_count), .last_i(a_last), .last_o(a_last_o),
`endif
    .unpacked_o(a_unp), .valid_o(a_valid_o), .ready_i(a_ready_i));

  unpacker_multi #(.packed_width_p(8), .elem_width_p(2), .msb_first_p(1'b1)) u_msb (
    .clk_i(clk), .reset_ni(reset_ni), .packed_i(a_packed), .valid_i(a_valid), .ready_o(m_ready_o),
`ifdef UNPACKER_MULTI_LAST_EN
    .count_i(a_count), .last_i(a_last), .last_o(m_last_o),
`endif
    .unpacked_o(m_unp), .valid_o(m_valid_o), .ready_i(a_ready_i));

  unpacker_multi #(.packed_width_p(32), .elem_width_p(8), .msb_first_p(1'b0)) u_wide (
    .clk_i(clk), .reset_ni(reset_ni), .packed_i(w_packed), .valid_i(w_valid), .ready_o(w_ready_o),
`ifdef UNPACKER_MULTI_LAST_EN
    .count_i(w_count), .last_i(w_last), .last_o(w_last_o),
`endif
    .unpacked_o(w_unp), .valid_o(w_valid_o), .ready_i(w_ready_i));

  int total = 0;
  int bad   = 0;

  // Expected element streams: {last, data}
  logic [8:0] exp_a[$];
  logic [8:0] exp_m[$];
  logic [8:0] exp_w[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, req);
    end
  endtask

  function automatic logic [7:0] slice_of(input logic [31:0] w, input int idx, input int width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return 8'((w >> (idx * width)) & mask);
  endfunction

  function automatic int n_of(input logic [1:0] cnt);
    if (!LAST_EN) return ELEMS;
    return int'(cnt) + 1;
  endfunction

  // Reference: a word of n elements, taken from the LSB end (sel 0/2) or
  // the MSB end (sel 1); a frame mark lands on the word's final element.
  task automatic push_word(input int sel, input logic [31:0] w, input int n,
                           input logic lst, input int width);
    int         idx;
    logic [8:0] e;
    for (int k = 0; k < n; k++) begin
      idx = (sel == 1) ? (ELEMS - 1 - k) : k;
      e   = {lst && (k == n - 1), slice_of(w, idx, width)};
      if (sel == 0) exp_a.push_back(e);
      else if (sel == 1) exp_m.push_back(e);
      else exp_w.push_back(e);
    end
  endtask

  task automatic pop_chk(input int sel, input string name, input logic [7:0] d, input logic l);
    logic [8:0] e;
    int         pending;
    pending = (sel == 0) ? exp_a.size() : (sel == 1) ? exp_m.size() : exp_w.size();
    chk({name, "_output_expected"}, 32'(pending != 0), 32'd1);
    if (pending != 0) begin
      if (sel == 0) e = exp_a.pop_front();
      else if (sel == 1) e = exp_m.pop_front();
      else e = exp_w.pop_front();
      chk({name, "_data"}, 32'(d), 32'(e[7:0]));
      chk({name, "_last"}, 32'(l), 32'(e[8]));
    end
  endtask

  // Scoreboard and hold-rule monitor, sampled mid-cycle.
  logic       hold_a, hold_m, hold_w;
  logic [2:0] held_a, held_m;
  logic [8:0] held_w;

  always @(negedge clk) begin
    if (reset_ni) begin
      if (a_valid_o && a_ready_i) pop_chk(0, "lsb", 8'(a_unp), a_last_o);
      if (m_valid_o && a_ready_i) pop_chk(1, "msb", 8'(m_unp), m_last_o);
      if (w_valid_o && w_ready_i) pop_chk(2, "wide", w_unp, w_last_o);
      if (a_valid && a_ready_o) push_word(0, 32'(a_packed), n_of(a_count), LAST_EN && a_last, 2);
      if (a_valid && m_ready_o) push_word(1, 32'(a_packed), n_of(a_count), LAST_EN && a_last, 2);
      if (w_valid && w_ready_o) push_word(2, w_packed, n_of(w_count), LAST_EN && w_last, 8);
      if (hold_a) begin
        chk("lsb_hold_valid", 32'(a_valid_o), 32'd1);
        chk("lsb_hold_data", 32'({a_last_o, a_unp}), 32'(held_a));
      end
      if (hold_m) begin
        chk("msb_hold_valid", 32'(m_valid_o), 32'd1);
        chk("msb_hold_data", 32'({m_last_o, m_unp}), 32'(held_m));
      end
      if (hold_w) begin
        chk("wide_hold_valid", 32'(w_valid_o), 32'd1);
        chk("wide_hold_data", 32'({w_last_o, w_unp}), 32'(held_w));
      end
    end
    hold_a <= reset_ni && a_valid_o && !a_ready_i;
    hold_m <= reset_ni && m_valid_o && !a_ready_i;
    hold_w <= reset_ni && w_valid_o && !w_ready_i;
    held_a <= {a_last_o, a_unp};
    held_m <= {m_last_o, m_unp};
    held_w <= {w_last_o, w_unp};
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  int bp_a   [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
  int bp_m   [8] = '{3, 2, 1, 0, 0, 1, 2, 3};
  int bp_rdy [8] = '{0, 0, 1, 0, 0, 0, 1, 1};
  int wide_e [8] = '{32'hEF, 32'hBE, 32'hAD, 32'hDE, 32'h78, 32'h56, 32'h34, 32'h12};
  int lp_a   [6] = '{3, 3, 0, 1, 2, 3};
  int lp_m   [6] = '{3, 3, 3, 2, 1, 0};
  int lp_l   [6] = '{0, 1, 0, 0, 0, 0};

  int drain_cycles;

  initial begin
    reset_ni  = 1'b0;
    a_packed  = '0;  a_valid = 1'b0; a_ready_i = 1'b1; a_count = 2'd3; a_last = 1'b0;
    w_packed  = '0;  w_valid = 1'b0; w_ready_i = 1'b1; w_count = 2'd3; w_last = 1'b0;
    hold_a = 1'b0; hold_m = 1'b0; hold_w = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    mid();
    chk("rst_lsb_valid", 32'(a_valid_o), 32'd0);
    chk("rst_lsb_data",  32'(a_unp),     32'd0);
    chk("rst_lsb_ready", 32'(a_ready_o), 32'd0);
    chk("rst_lsb_last",  32'(a_last_o),  32'd0);
    chk("rst_msb_valid", 32'(m_valid_o), 32'd0);
    chk("rst_wide_valid", 32'(w_valid_o), 32'd0);
    chk("rst_wide_data",  32'(w_unp),     32'd0);
    chk("rst_wide_ready", 32'(w_ready_o), 32'd0);
    nxt();
    reset_ni = 1'b1;
    mid();
    chk("post_rst_lsb_ready", 32'(a_ready_o), 32'd1);
    chk("post_rst_wide_ready", 32'(w_ready_o), 32'd1);
    chk("post_rst_lsb_valid", 32'(a_valid_o), 32'd0);

    // Basic order and latency, word 0xE4
    nxt();
    a_packed = 8'hE4; a_valid = 1'b1;
    mid();
    chk("basic_ready_idle", 32'(a_ready_o), 32'd1);
    nxt();
    a_valid = 1'b0; a_packed = 8'h00;
    mid();
    chk("basic_latency_valid", 32'(a_valid_o), 32'd0);
    chk("basic_busy_ready", 32'(a_ready_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      mid();
      chk("basic_valid", 32'(a_valid_o), 32'd1);
      chk("basic_lsb_elem", 32'(a_unp), 32'(k));
      chk("basic_msb_elem", 32'(m_unp), 32'(3 - k));
      chk("basic_ready", 32'(a_ready_o), (k >= 2) ? 32'd1 : 32'd0);
    end
    nxt();
    mid();
    chk("basic_drained", 32'(a_valid_o), 32'd0);

    // Backpressure plus back-to-back words 0xE4, 0x1B
    nxt();
    a_packed = 8'hE4; a_valid = 1'b1;
    nxt();
    a_packed = 8'h1B;
    mid();
    chk("bp_ready_busy", 32'(a_ready_o), 32'd0);
    nxt();
    a_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      mid();
      chk("bp_stall_valid", 32'(a_valid_o), 32'd1);
      chk("bp_stall_data", 32'(a_unp), 32'd0);
      chk("bp_stall_ready", 32'(a_ready_o), 32'd0);
      nxt();
    end
    a_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mid();
      chk("b2b_valid", 32'(a_valid_o), 32'd1);
      chk("b2b_lsb_elem", 32'(a_unp), 32'(bp_a[i]));
      chk("b2b_msb_elem", 32'(m_unp), 32'(bp_m[i]));
      chk("b2b_ready", 32'(a_ready_o), 32'(bp_rdy[i]));
      nxt();
      if (i == 2) a_valid = 1'b0;
    end
    mid();
    chk("b2b_drained", 32'(a_valid_o), 32'd0);

    // Wide 32/8, second word offered during the final move
    nxt();
    w_packed = 32'hDEADBEEF; w_valid = 1'b1;
    nxt();
    w_valid = 1'b0;
    mid();
    chk("wide_latency_valid", 32'(w_valid_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      nxt();
      if (i == 2) begin
        w_packed = 32'h12345678; w_valid = 1'b1;
      end
      if (i == 3) w_valid = 1'b0;
      mid();
      chk("wide_valid", 32'(w_valid_o), 32'd1);
      chk("wide_elem", 32'(w_unp), 32'(wide_e[i]));
      if (i == 2) chk("wide_accept_ready", 32'(w_ready_o), 32'd1);
      if (i == 3) chk("wide_reload_busy", 32'(w_ready_o), 32'd0);
    end
    nxt();
    mid();
    chk("wide_drained", 32'(w_valid_o), 32'd0);

`ifdef UNPACKER_MULTI_LAST_EN
    // Partial word with frame end, then a full word without
    nxt();
    a_packed = 8'hFF; a_count = 2'd1; a_last = 1'b1; a_valid = 1'b1;
    nxt();
    a_packed = 8'hE4; a_count = 2'd3; a_last = 1'b0;
    mid();
    chk("last_ready_busy", 32'(a_ready_o), 32'd0);
    for (int i = 0; i < 6; i++) begin
      nxt();
      if (i == 1) a_valid = 1'b0;
      mid();
      chk("last_valid", 32'(a_valid_o), 32'd1);
      chk("last_lsb_elem", 32'(a_unp), 32'(lp_a[i]));
      chk("last_msb_elem", 32'(m_unp), 32'(lp_m[i]));
      chk("last_flag", 32'(a_last_o), 32'(lp_l[i]));
      if (i == 0) chk("last_partial_final_ready", 32'(a_ready_o), 32'd1);
    end
    nxt();
    mid();
    chk("last_drained", 32'(a_valid_o), 32'd0);
`endif

    // Reset in the middle of a word
    nxt();
    a_packed = 8'hE4; a_valid = 1'b1;
    nxt();
    a_valid = 1'b0;
    nxt();
    nxt();
    mid();
    chk("rstmid_pre_elem", 32'(a_unp), 32'd1);
    #1;
    reset_ni = 1'b0;
    exp_a.delete(); exp_m.delete(); exp_w.delete();
    #1;
    chk("rstmid_valid", 32'(a_valid_o), 32'd0);
    chk("rstmid_data", 32'(a_unp), 32'd0);
    chk("rstmid_ready", 32'(a_ready_o), 32'd0);
    chk("rstmid_msb_valid", 32'(m_valid_o), 32'd0);
    chk("rstmid_msb_data", 32'(m_unp), 32'd0);
    @(posedge clk);
    nxt();
    reset_ni = 1'b1;
    mid();
    chk("rstmid_release_ready", 32'(a_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("rstmid_no_stale", 32'(a_valid_o), 32'd0);
      nxt();
    end

    // Randomized traffic against the reference streams
    for (int c = 0; c < 800; c++) begin
      nxt();
      a_valid   = 1'($urandom_range(0, 1));
      a_packed  = 8'($urandom);
      a_count   = 2'($urandom);
      a_last    = 1'($urandom);
      a_ready_i = ($urandom_range(0, 3) != 0);
      w_valid   = 1'($urandom_range(0, 1));
      w_packed  = $urandom;
      w_count   = 2'($urandom);
      w_last    = 1'($urandom);
      w_ready_i = ($urandom_range(0, 2) != 0);
    end
    nxt();
    a_valid = 1'b0; a_ready_i = 1'b1;
    w_valid = 1'b0; w_ready_i = 1'b1;
    drain_cycles = 0;
    while ((exp_a.size() + exp_m.size() + exp_w.size()) != 0 && drain_cycles < 40) begin
      mid();
      #1;
      drain_cycles++;
      nxt();
    end
    chk("drain_queues_empty", 32'(exp_a.size() + exp_m.size() + exp_w.size()), 32'd0);
    nxt();
    mid();
    chk("final_lsb_idle", 32'(a_valid_o), 32'd0);
    chk("final_wide_idle", 32'(w_valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
